// File: rtl/title_sequence_controller.sv
// Sequences the full-screen titles: each one scrolls up from the bottom edge,
// holds centred, blinks, then hands over to the next title in the list.
//
// state  | meaning
// IDLE   | waiting for startReq; title hidden
// SCROLL | moving topLeftY up by SCROLL_STEP per frame tick
// HOLD   | parked at HOLD_Y for HOLD_FRAMES ticks
// BLINK  | toggling titleEnable every BLINK_PERIOD ticks
module title_sequence_controller #(
  parameter int SCREEN_H      = 480,
  parameter int X_POS         = 288,
  parameter int HOLD_Y        = 232,
  parameter int SCROLL_STEP   = 2,
  parameter int HOLD_FRAMES   = 120,
  parameter int BLINK_PERIOD  = 16,
  parameter int BLINK_TOGGLES = 6,
  parameter int NUM_TITLES    = 3
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        startReq,
  input  logic        skipReq,
  output logic [1:0]  titleSel,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic        titleEnable,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, SCROLL, HOLD, BLINK} state_t;

  localparam int CNT_MAX = (HOLD_FRAMES > BLINK_PERIOD) ? HOLD_FRAMES : BLINK_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TGL_W   = $clog2(BLINK_TOGGLES + 1);

  localparam logic [10:0]      Y_START    = 11'(SCREEN_H);
  localparam logic [10:0]      Y_HOLD     = 11'(HOLD_Y);
  localparam logic [10:0]      Y_STEP     = 11'(SCROLL_STEP);
  localparam logic [10:0]      Y_LAND     = 11'(HOLD_Y + SCROLL_STEP);
  localparam logic [10:0]      X_CONST    = 11'(X_POS);
  localparam logic [1:0]       LAST_SEL   = 2'(NUM_TITLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [CNT_W-1:0] BLINK_LOAD = CNT_W'(BLINK_PERIOD - 1);
  localparam logic [TGL_W-1:0] TGL_LOAD   = TGL_W'(BLINK_TOGGLES);

  state_t           state;
  logic [CNT_W-1:0] frame_cnt;
  logic [TGL_W-1:0] toggles_left;

  logic frame_tc;
  logic last_toggle;
  logic advance;
  logic is_last;

  always_comb begin
    frame_tc    = startOfFrame && (frame_cnt == '0);
    last_toggle = (state == BLINK) && frame_tc && (toggles_left == TGL_W'(1));
    advance     = (((state == HOLD) || (state == BLINK)) && skipReq) || last_toggle;
    is_last     = (titleSel == LAST_SEL);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= IDLE;
      titleSel     <= 2'd0;
      topLeftX     <= X_CONST;
      topLeftY     <= Y_START;
      titleEnable  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      frame_cnt    <= '0;
      toggles_left <= '0;
    end else begin
      topLeftX <= X_CONST;
      done     <= 1'b0;
      if (advance) begin
        frame_cnt    <= '0;
        toggles_left <= '0;
        if (is_last) begin
          state       <= IDLE;
          titleEnable <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b1;
        end else begin
          state       <= SCROLL;
          titleSel    <= titleSel + 2'd1;
          topLeftY    <= Y_START;
          titleEnable <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (startReq) begin
              state        <= SCROLL;
              titleSel     <= 2'd0;
              topLeftY     <= Y_START;
              titleEnable  <= 1'b1;
              busy         <= 1'b1;
              frame_cnt    <= '0;
              toggles_left <= '0;
            end
          end
          SCROLL: begin
            if (skipReq) begin
              topLeftY  <= Y_HOLD;
              frame_cnt <= HOLD_LOAD;
              state     <= HOLD;
            end else if (startOfFrame) begin
              // land on HOLD_Y on the step that reaches it; never subtract past it
              if (topLeftY <= Y_LAND) begin
                topLeftY  <= Y_HOLD;
                frame_cnt <= HOLD_LOAD;
                state     <= HOLD;
              end else begin
                topLeftY <= topLeftY - Y_STEP;
              end
            end
          end
          HOLD: begin
            if (frame_tc) begin
              frame_cnt    <= BLINK_LOAD;
              toggles_left <= TGL_LOAD;
              state        <= BLINK;
            end else if (startOfFrame) begin
              frame_cnt <= frame_cnt - 1'b1;
            end
          end
          BLINK: begin
            if (frame_tc) begin
              frame_cnt    <= BLINK_LOAD;
              titleEnable  <= ~titleEnable;
              toggles_left <= toggles_left - 1'b1;
            end else if (startOfFrame) begin
              frame_cnt <= frame_cnt - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
